// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, digit-index type and anode decode for the seven-segment scan driver
package seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int GUARD_DEFAULT = 2;
  typedef logic [1:0] digit_idx_t;
  function automatic logic [NUM_DIGITS-1:0] anode_sel(input digit_idx_t idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: free-running slot counter 0..SCAN_DIV-1 with a tick on the last count
module scan_prescaler #(
  parameter int SCAN_DIV = 12500
) (
  input  logic        clk,
  input  logic        clear,
  output logic [15:0] cnt,
  output logic        tick
);
  logic [15:0] cnt_q, cnt_d;
  assign tick = cnt_q == 16'(SCAN_DIV - 1);
  assign cnt = cnt_q;
  // next count wraps to zero on the tick
  always_comb cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
  // counter register, cleared asynchronously
  always_ff @(posedge clk or negedge clear)
    if (!clear) cnt_q <= 16'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit multiplexed 7-seg scanner with frame-synchronous shadow load; optional PWM dimming via SEG_DIM_EN
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 12500,
  parameter int GUARD    = GUARD_DEFAULT
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [7:0] led0,
  input  logic [7:0] led1,
  input  logic [7:0] led2,
  input  logic [7:0] led3,
  input  logic       update_req,
  input  logic [3:0] blank_mask,
`ifdef SEG_DIM_EN
  input  logic [2:0] bright,
`endif
  output logic [7:0] seg_n,
  output logic [3:0] an_n,
  output logic       frame_done
);
  logic [15:0] cnt;
  logic tick, wrap, capture, lit, duty_ok;
  digit_idx_t idx_q, idx_d;
  logic pending_q, pending_d, loaded_q, loaded_d, frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0][7:0] shadow_q, shadow_d;
  logic [7:0] seg_n_q, seg_n_d;
  logic [3:0] an_n_q, an_n_d;

  scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
    .clk  (clk),
    .clear(clear),
    .cnt  (cnt),
    .tick (tick)
  );

`ifdef SEG_DIM_EN
  logic [2:0] bright_q, bright_d;
  logic [31:0] lit_end;
  // brightness is latched per slot; the lit window ends at GUARD + (bright+1)/8 of the post-guard time
  always_comb begin
    bright_d = tick ? bright : bright_q;
    lit_end = 32'(GUARD) + (((32'(bright_q) + 32'd1) * 32'(SCAN_DIV - GUARD)) >> 3);
  end
  // brightness register, full duty after reset
  always_ff @(posedge clk or negedge clear)
    if (!clear) bright_q <= 3'd7;
    else bright_q <= bright_d;
  assign duty_ok = {16'd0, cnt} < lit_end;
`else
  assign duty_ok = 1'b1;
`endif

  // next-state: digit advance, deferred shadow load at frame wrap, and output decode
  always_comb begin
    wrap = tick && idx_q == digit_idx_t'(NUM_DIGITS - 1);
    capture = wrap && (pending_q || update_req);
    idx_d = tick ? idx_q + 2'd1 : idx_q;
    pending_d = !wrap && (pending_q || update_req);
    loaded_d = loaded_q || capture;
    shadow_d = capture ? {led3, led2, led1, led0} : shadow_q;
    frame_done_d = wrap;
    lit = loaded_q && cnt >= 16'(GUARD) && !blank_mask[idx_q] && duty_ok;
    an_n_d = lit ? anode_sel(idx_q) : 4'hF;
    seg_n_d = lit ? shadow_q[idx_q] : SEG_BLANK;
  end

  // state and output registers; clear blanks the display immediately and drops any pending load
  always_ff @(posedge clk or negedge clear)
    if (!clear) begin
      idx_q <= '0;
      pending_q <= 1'b0;
      loaded_q <= 1'b0;
      shadow_q <= {NUM_DIGITS{SEG_BLANK}};
      frame_done_q <= 1'b0;
      an_n_q <= 4'hF;
      seg_n_q <= SEG_BLANK;
    end else begin
      idx_q <= idx_d;
      pending_q <= pending_d;
      loaded_q <= loaded_d;
      shadow_q <= shadow_d;
      frame_done_q <= frame_done_d;
      an_n_q <= an_n_d;
      seg_n_q <= seg_n_d;
    end

  assign seg_n = seg_n_q;
  assign an_n = an_n_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: self-checking bench with a cycle model scoreboard plus table-driven frame checks
module tb_seg_scan_driver;
  localparam int SD = 8;
  localparam int GD = 2;

  logic clk = 1'b0;
  logic clear = 1'b0;
  logic update_req = 1'b0;
  logic [7:0] led0 = 8'h00, led1 = 8'h00, led2 = 8'h00, led3 = 8'h00;
  logic [3:0] blank_mask = 4'h0;
`ifdef SEG_DIM_EN
  logic [2:0] bright = 3'd7;
`endif
  logic [7:0] seg_n;
  logic [3:0] an_n;
  logic frame_done;

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(SD), .GUARD(GD)) dut (
    .clk       (clk),
    .clear     (clear),
    .led0      (led0),
    .led1      (led1),
    .led2      (led2),
    .led3      (led3),
    .update_req(update_req),
    .blank_mask(blank_mask),
`ifdef SEG_DIM_EN
    .bright    (bright),
`endif
    .seg_n     (seg_n),
    .an_n      (an_n),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic fd;
  } exp_t;

  typedef struct {
    logic [31:0] leds;
    logic [3:0] mask;
    logic [15:0] ean;
    logic [31:0] eseg;
  } vec_t;

  exp_t q[$];
  exp_t m_exp, c_exp;
  int n_pass = 0, n_tot = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // reference model: outputs after an edge come from the state before it
  int m_cnt = 0, m_idx = 0, m_lim = SD;
  logic m_pend = 1'b0, m_ld = 1'b0, m_lit;
  logic [2:0] m_br = 3'd7;
  logic [7:0] m_sh[4] = '{default: 8'hFF};
  logic [3:0] an_tab[4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  always @(posedge clk or negedge clear) begin
    if (!clear) begin
      m_cnt = 0;
      m_idx = 0;
      m_pend = 1'b0;
      m_ld = 1'b0;
      m_br = 3'd7;
      m_sh = '{default: 8'hFF};
      q.delete();
    end else begin
      m_lim = SD;
`ifdef SEG_DIM_EN
      m_lim = GD + ((int'(m_br) + 1) * (SD - GD)) / 8;
`endif
      m_lit = m_ld && m_cnt >= GD && m_cnt < m_lim && !blank_mask[m_idx];
      m_exp.an = m_lit ? an_tab[m_idx] : 4'hF;
      m_exp.seg = m_lit ? m_sh[m_idx] : 8'hFF;
      m_exp.fd = m_cnt == SD - 1 && m_idx == 3;
      q.push_back(m_exp);
      if (m_exp.fd && (m_pend || update_req)) begin
        m_sh = '{led0, led1, led2, led3};
        m_ld = 1'b1;
      end
      m_pend = !m_exp.fd && (m_pend || update_req);
      if (m_cnt == SD - 1) begin
        m_idx = (m_idx + 1) % 4;
`ifdef SEG_DIM_EN
        m_br = bright;
`endif
      end
      m_cnt = (m_cnt + 1) % SD;
    end
  end

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (!clear) begin
      check("reset_an", an_n, 4'hF);
      check("reset_seg", seg_n, 8'hFF);
      check("reset_fd", frame_done, 1'b0);
    end else if (q.size() > 0) begin
      c_exp = q.pop_front();
      check("sb_an", an_n, c_exp.an);
      check("sb_seg", seg_n, c_exp.seg);
      check("sb_fd", frame_done, c_exp.fd);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fd();
    int k = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("fd_wait", k < 100, 1'b1);
  endtask

  task automatic pulse_upd();
    #1 update_req = 1'b1;
    @(negedge clk);
    #1 update_req = 1'b0;
  endtask

  task automatic slot_check(string nm, logic [15:0] ea, logic [31:0] es);
    cyc(5);
    for (int s = 0; s < 4; s++) begin
      if (s > 0) cyc(8);
      check($sformatf("%s_an%0d", nm, s), an_n, ea[s*4+:4]);
      check($sformatf("%s_seg%0d", nm, s), seg_n, es[s*8+:8]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[3];
    int k;
    vt[0] = '{32'hB0A4F9C0, 4'b0000, 16'h7BDE, 32'hB0A4F9C0};
    vt[1] = '{32'hB0A4F9C0, 4'b0100, 16'h7FDE, 32'hB0FFF9C0};
    vt[2] = '{32'h829299A4, 4'b1001, 16'hFBDF, 32'hFF9299FF};

    cyc(3);
    check("rst_pending", dut.pending_q, 1'b0);
    #1 clear = 1'b1;

    // idle after reset: dark, frame every 32 clocks
    wait_fd();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_done !== 1'b1 && k < 100);
    check("frame_period", k, 32);

    // load and scan table
    for (int i = 0; i < 3; i++) begin
      cyc(2);
      #1 {led3, led2, led1, led0} = vt[i].leds;
      blank_mask = vt[i].mask;
      pulse_upd();
      cyc(2);
      if (i == 0) begin
        check("preload_an", an_n, 4'hF);
        check("preload_seg", seg_n, 8'hFF);
      end
      wait_fd();
      slot_check($sformatf("row%0d", i), vt[i].ean, vt[i].eseg);
    end

    // tearing: change without request, then request on the wrap tick
    wait_fd();
    cyc(2);
    #1 blank_mask = 4'b0000;
    led0 = 8'h99;
    wait_fd();
    cyc(5);
    check("no_tear_seg", seg_n, 8'hA4);
    check("no_tear_pend", dut.pending_q, 1'b0);
    cyc(26);
    #1 update_req = 1'b1;
    @(negedge clk);
    check("wrap_fd", frame_done, 1'b1);
    check("wrap_pending", dut.pending_q, 1'b0);
    #1 update_req = 1'b0;
    cyc(4);
    check("wrap_load_an", an_n, 4'hE);
    check("wrap_load_seg", seg_n, 8'h99);

    // mid-frame reset with a pending update
    wait_fd();
    #1 {led3, led2, led1, led0} = 32'h88888888;
    cyc(15);
    pulse_upd();
    check("pend_set", dut.pending_q, 1'b1);
    cyc(3);
    check("pre_clear_an", an_n, 4'hB);
    #2 clear = 1'b0;
    #1;
    check("async_an", an_n, 4'hF);
    check("async_seg", seg_n, 8'hFF);
    check("async_pend", dut.pending_q, 1'b0);
    cyc(2);
    #1 clear = 1'b1;
    wait_fd();
    slot_check("post_rst", 16'hFFFF, 32'hFFFFFFFF);

`ifdef SEG_DIM_EN
    pulse_upd();
    for (int b = 0; b < 2; b++) begin
      int cnt_s[4];
      #1 bright = (b == 0) ? 3'd3 : 3'd7;
      wait_fd();
      wait_fd();
      cnt_s = '{0, 0, 0, 0};
      for (int n = 1; n <= 32; n++) begin
        @(negedge clk);
        if (an_n !== 4'hF) cnt_s[(n - 1) / 8]++;
      end
      for (int s = 0; s < 4; s++)
        check($sformatf("dim%0d_slot%0d", b, s), cnt_s[s], (b == 0) ? 3 : 6);
    end
`endif

    cyc(3);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 12500; clocks per digit slot (4 kHz per digit at 50 MHz); legal range GUARD+2 to 2^16.
REQ-002 SHALL have parameter GUARD, default 2; blanking clocks at the start of each slot.
REQ-003 SHALL have port clk, input, 1 bit; single clock; all state on its rising edge.
REQ-004 SHALL have port clear, input, 1 bit; reset is asynchronous and active-low (0 = reset).
REQ-005 SHALL have ports led0, led1, led2 and led3, each input, 8 bits; digit patterns from the level/LED encoder; active-low segments; bit7 = dp.
REQ-006 SHALL have port update_req, input, 1 bit; one-cycle request to load led0..led3 into shadow registers.
REQ-007 SHALL have port blank_mask, input, 4 bits; bit i = 1 forces digit i dark; sampled live, not shadowed.
REQ-008 SHALL have port seg_n, output, 8 bits; registered shared cathode drive; active-low.
REQ-009 SHALL have port an_n, output, 4 bits; registered anode select; active-low; at most one bit low.
REQ-010 SHALL have port frame_done, output, 1 bit; one-cycle pulse at each frame wrap.

Function
REQ-011 SHALL run a prescaler cnt over 0..SCAN_DIV-1, wrapping to 0; a tick SHALL occur on the cycle cnt==SCAN_DIV-1.
REQ-012 SHALL advance digit index idx 0->1->2->3->0 on each tick.
REQ-013 SHALL pulse frame_done for exactly one cycle, registered, on the tick where idx wraps 3->0.
REQ-014 SHALL set a pending flag on update_req; at the frame wrap tick, if pending or update_req is high, it SHALL copy led0..led3 into shadow0..3 and clear pending.
REQ-015 SHALL capture immediately when update_req coincides with the wrap tick, leaving pending at 0.
REQ-016 SHALL keep a single pending flag when multiple update_req pulses arrive within one frame; values present at the wrap are the ones loaded.
REQ-017 SHALL never change shadow registers mid-frame, so that no tearing occurs.
REQ-018 SHALL drive an_n=4'hF and seg_n=8'hFF whenever cnt<GUARD (ghosting guard).
REQ-019 Otherwise, SHALL drive an_n[idx]=0 and seg_n=shadow[idx]; if blank_mask[idx]=1, an_n=4'hF and seg_n=8'hFF.
REQ-020 SHALL register outputs, giving one cycle of latency from cnt/idx state to pins.
REQ-021 SHALL never assert two anodes low in the same cycle, including at the wrap cycle.

Reset
REQ-022 While clear=0, SHALL hold cnt=0, idx=0, pending=0, shadow0..3=8'hFF, seg_n=8'hFF, an_n=4'hF and frame_done=0.
REQ-023 When clear asserts mid-frame, SHALL blank outputs asynchronously and discard any pending update.
REQ-024 After clear deasserts, SHALL start at slot 0 with cnt=0 and keep the display dark until the first update_req is captured at a wrap.

Configuration
REQ-025 With SEG_DIM_EN defined, SHALL add input bright[2:0]; the digit SHALL be lit only while GUARD<=cnt<GUARD+((bright+1)*(SCAN_DIV-GUARD))/8 and dark otherwise; bright is sampled at each tick.
REQ-026 With SEG_DIM_EN undefined, SHALL omit the bright port and keep the digit lit for the whole post-guard slot (full duty).

Structure
REQ-027 SHALL take NUM_DIGITS=4, SEG_BLANK=8'hFF, the digit-index typedef (2 bits) and the GUARD default from shared package seg_pkg.
REQ-028 SHALL implement the prescaler as sub-module scan_prescaler (outputs cnt and tick); the digit index, shadow buffer and output registers SHALL stay in the top module.

Verification (SCAN_DIV=8, GUARD=2, no SEG_DIM_EN unless stated)
REQ-029 SHALL cover reset release: 40 cycles with no update_req -> seg_n=8'hFF, an_n=4'hF throughout; frame_done every 32 cycles.
REQ-030 SHALL cover load and scan: led0..3=8'hC0,F9,A4,B0 with update_req pulsed mid-frame 0 -> frame 0 still dark; after the wrap, each slot shows an_n=E,D,B,7 with matching seg_n for 6 cycles after 2 dark guard cycles.
REQ-031 SHALL cover tearing: led0 changed to 8'h99 mid-frame with no update_req -> display unchanged; update_req on the exact wrap tick -> 8'h99 shown in the next slot 0, pending=0.
REQ-032 SHALL cover blanking: blank_mask=4'b0100 -> slot 2 has an_n=4'hF and seg_n=8'hFF; other slots unaffected.
REQ-033 SHALL cover mid-frame reset: clear low in slot 2 with update pending -> immediate blank; after release, display dark and the pending update lost.
REQ-034 SHALL cover dimming with SEG_DIM_EN and bright=3 -> each digit lit exactly 3 of 8 cycles per slot (cnt 2..4); bright=7 -> lit 6 of 8 cycles.
